// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues 1-cycle-latency ROM reads and
// buffers PC-tagged instructions in a shift FIFO that feeds decode over valid/ready.
module fetch_unit #(
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned RESET_PC  = 0,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              fetchEn,
   input  logic              jmp,
   input  logic [ADDR_W-1:0] jmpTarget,
   input  logic              branchTaken,
   input  logic [ADDR_W-1:0] branchPc,
   input  logic [ADDR_W-1:0] branchOffset,
   output logic              memReq,
   output logic [ADDR_W-1:0] memAddr,
   input  logic [DATA_W-1:0] memData,
   output logic              instrValid,
   output logic [DATA_W-1:0] instrOut,
   output logic [ADDR_W-1:0] instrPc,
   input  logic              instrReady
);

   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int unsigned OCC_W = CNT_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } entry_t;

   logic [ADDR_W-1:0]    fetchPc;
   logic [ADDR_W-1:0]    retPc;
   logic                 inflight;
   entry_t               entry [BUF_DEPTH];
   logic [BUF_DEPTH-1:0] valid;

   logic                 pop;
   logic                 extRedirect;
   logic                 full;
   logic                 push;
   logic                 replay;
   logic                 redirect;
   logic                 reqIssue;
   logic                 placed;
   logic [ADDR_W-1:0]    branchTarget;
   logic [ADDR_W-1:0]    redirTarget;
   logic [CNT_W-1:0]     count;
   entry_t               entryNext [BUF_DEPTH];
   logic [BUF_DEPTH-1:0] validShift;
   logic [BUF_DEPTH-1:0] validNext;

   assign pop          = valid[0] & instrReady;
   assign extRedirect  = jmp | branchTaken;
   assign full         = valid[BUF_DEPTH-1];
   assign branchTarget = branchPc + ADDR_W'(1) + branchOffset;

   // A return that finds the FIFO full is dropped and refetched from its own PC.
   assign push     = inflight & ~extRedirect & (~full | pop);
   assign replay   = inflight & ~extRedirect & full & ~pop;
   assign redirect = extRedirect | replay;

   always_comb begin
      redirTarget = retPc;
      if (jmp) begin
         redirTarget = jmpTarget;
      end else if (branchTaken) begin
         redirTarget = branchTarget;
      end
   end

   always_comb begin
      count = '0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
         count = count + CNT_W'(valid[i]);
      end
   end

   assign reqIssue = fetchEn & ~redirect &
                     ((OCC_W'(count) + OCC_W'(inflight)) < (OCC_W'(BUF_DEPTH) + OCC_W'(pop)));

   // Shift FIFO: entry 0 is always the head, so the outputs come straight from registers.
   always_comb begin
      entryNext  = entry;
      validShift = valid;
      placed     = 1'b0;
      if (pop) begin
         for (int i = 0; i < int'(BUF_DEPTH) - 1; i++) begin
            entryNext[i]  = entry[i + 1];
            validShift[i] = valid[i + 1];
         end
         validShift[BUF_DEPTH-1] = 1'b0;
      end
      validNext = validShift;
      if (extRedirect) begin
         validNext = '0;
      end else if (push) begin
         for (int i = 0; i < int'(BUF_DEPTH); i++) begin
            if (!validShift[i] && !placed) begin
               entryNext[i].pc    = retPc;
               entryNext[i].instr = memData;
               validNext[i]       = 1'b1;
               placed             = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         fetchPc  <= ADDR_W'(RESET_PC);
         memReq   <= 1'b0;
         memAddr  <= ADDR_W'(RESET_PC);
         inflight <= 1'b0;
         retPc    <= '0;
         valid    <= '0;
         for (int i = 0; i < int'(BUF_DEPTH); i++) begin
            entry[i] <= '0;
         end
      end else begin
         memReq   <= reqIssue;
         inflight <= memReq & ~redirect;
         retPc    <= memAddr;
         valid    <= validNext;
         entry    <= entryNext;
         if (redirect) begin
            fetchPc <= redirTarget;
         end else if (reqIssue) begin
            memAddr <= fetchPc;
            fetchPc <= fetchPc + ADDR_W'(1);
         end
      end
   end

   assign instrValid = valid[0];
   assign instrOut   = entry[0].instr;
   assign instrPc    = entry[0].pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a ROM model returns 0x1000_0000 + address and a
// monitor records every accepted instruction for stream comparisons.
module tb_fetch_unit;

   localparam int unsigned ADDR_W    = 5;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned BUF_DEPTH = 2;

   logic              clk = 1'b0;
   logic              rstN;
   logic              fetchEn;
   logic              jmp;
   logic [ADDR_W-1:0] jmpTarget;
   logic              branchTaken;
   logic [ADDR_W-1:0] branchPc;
   logic [ADDR_W-1:0] branchOffset;
   logic              memReq;
   logic [ADDR_W-1:0] memAddr;
   logic [DATA_W-1:0] memData = '0;
   logic              instrValid;
   logic [DATA_W-1:0] instrOut;
   logic [ADDR_W-1:0] instrPc;
   logic              instrReady;

   int tests = 0;
   int fails = 0;

   logic [ADDR_W-1:0] pcQ[$];
   logic [DATA_W-1:0] dataQ[$];

   fetch_unit #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0), .BUF_DEPTH(BUF_DEPTH)
   ) dut (
      .clk(clk), .rstN(rstN), .fetchEn(fetchEn), .jmp(jmp), .jmpTarget(jmpTarget),
      .branchTaken(branchTaken), .branchPc(branchPc), .branchOffset(branchOffset),
      .memReq(memReq), .memAddr(memAddr), .memData(memData),
      .instrValid(instrValid), .instrOut(instrOut), .instrPc(instrPc),
      .instrReady(instrReady)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (memReq) memData <= 32'h1000_0000 + 32'(memAddr);
   end

   always @(negedge clk) begin
      if (rstN && instrValid && instrReady) begin
         pcQ.push_back(instrPc);
         dataQ.push_back(instrOut);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clearQ();
      pcQ.delete();
      dataQ.delete();
   endtask

   task automatic doReset();
      rstN = 1'b0; fetchEn = 1'b0; instrReady = 1'b0; jmp = 1'b0; branchTaken = 1'b0;
      jmpTarget = '0; branchPc = '0; branchOffset = '0;
      clearQ();
      tick(2);
   endtask

   // Accepted stream must be startPc, startPc+1, ... (mod 32) with matching ROM words.
   task automatic checkStream(input string tag, input int startPc, input int minLen);
      int expPc;
      checkEq({tag, "_len"}, 32'(pcQ.size() >= minLen), 32'd1);
      for (int j = 0; j < pcQ.size(); j++) begin
         expPc = (startPc + j) % 32;
         checkEq($sformatf("%s_pc%0d", tag, j), 32'(pcQ[j]), 32'(expPc));
         checkEq($sformatf("%s_data%0d", tag, j), dataQ[j], 32'h1000_0000 + 32'(expPc));
      end
   endtask

   initial begin
      doReset();
      checkEq("rst_memReq", 32'(memReq), 32'd0);
      checkEq("rst_memAddr", 32'(memAddr), 32'd0);
      checkEq("rst_valid", 32'(instrValid), 32'd0);
      checkEq("rst_instrOut", instrOut, 32'd0);
      checkEq("rst_instrPc", 32'(instrPc), 32'd0);

      // Streaming from reset: request in cycle 1, first instruction in cycle 3
      rstN = 1'b1; fetchEn = 1'b1; instrReady = 1'b1;
      tick(1);
      checkEq("t1_req_c1", 32'(memReq), 32'd1);
      checkEq("t1_addr_c1", 32'(memAddr), 32'd0);
      checkEq("t1_valid_c1", 32'(instrValid), 32'd0);
      tick(1);
      checkEq("t1_req_c2", 32'(memReq), 32'd1);
      checkEq("t1_addr_c2", 32'(memAddr), 32'd1);
      checkEq("t1_valid_c2", 32'(instrValid), 32'd0);
      for (int k = 0; k < 8; k++) begin
         tick(1);
         checkEq($sformatf("t1_valid%0d", k), 32'(instrValid), 32'd1);
         checkEq($sformatf("t1_pc%0d", k), 32'(instrPc), 32'(k));
         checkEq($sformatf("t1_out%0d", k), instrOut, 32'h1000_0000 + 32'(k));
         checkEq($sformatf("t1_addr%0d", k), 32'(memAddr), 32'(k + 2));
      end

      // Backpressure after one accept: head holds at PC 1, no requests, then resume
      doReset();
      rstN = 1'b1; fetchEn = 1'b1; instrReady = 1'b1;
      tick(4);
      instrReady = 1'b0;
      checkEq("t2_head_c4", 32'(instrPc), 32'd1);
      tick(1);
      for (int k = 0; k < 6; k++) begin
         checkEq($sformatf("t2_req%0d", k), 32'(memReq), 32'd0);
         checkEq($sformatf("t2_valid%0d", k), 32'(instrValid), 32'd1);
         checkEq($sformatf("t2_pc%0d", k), 32'(instrPc), 32'd1);
         checkEq($sformatf("t2_out%0d", k), instrOut, 32'h1000_0001);
         tick(1);
      end
      instrReady = 1'b1;
      tick(10);
      checkStream("t2", 0, 8);

      // Jump to 20 while the FIFO holds PCs 4 and 5 with PC 6 returning
      doReset();
      rstN = 1'b1; fetchEn = 1'b1; instrReady = 1'b1;
      tick(7);
      instrReady = 1'b0;
      checkEq("t3_head_c7", 32'(instrPc), 32'd4);
      tick(1);
      checkEq("t3_hold_valid", 32'(instrValid), 32'd1);
      checkEq("t3_hold_pc", 32'(instrPc), 32'd4);
      jmp = 1'b1; jmpTarget = 5'd20;
      tick(1);
      jmp = 1'b0; instrReady = 1'b1;
      checkEq("t3_flush_valid", 32'(instrValid), 32'd0);
      checkEq("t3_flush_req", 32'(memReq), 32'd0);
      clearQ();
      tick(1);
      checkEq("t3_req_tgt", 32'(memReq), 32'd1);
      checkEq("t3_addr_tgt", 32'(memAddr), 32'd20);
      checkEq("t3_valid_c10", 32'(instrValid), 32'd0);
      tick(2);
      checkEq("t3_valid_c12", 32'(instrValid), 32'd1);
      checkEq("t3_pc_c12", 32'(instrPc), 32'd20);
      tick(6);
      checkStream("t3", 20, 5);

      // Taken branch: 3 + 1 + (-2) = 2; then jump beats a simultaneous branch
      doReset();
      rstN = 1'b1; fetchEn = 1'b1; instrReady = 1'b1;
      tick(5);
      branchTaken = 1'b1; branchPc = 5'd3; branchOffset = 5'b11110;
      tick(1);
      branchTaken = 1'b0;
      checkEq("t4_br_valid", 32'(instrValid), 32'd0);
      checkEq("t4_br_req", 32'(memReq), 32'd0);
      clearQ();
      tick(8);
      checkStream("t4br", 2, 4);
      jmp = 1'b1; jmpTarget = 5'd9;
      branchTaken = 1'b1; branchPc = 5'd3; branchOffset = 5'b11110;
      tick(1);
      jmp = 1'b0; branchTaken = 1'b0;
      checkEq("t4_jb_valid", 32'(instrValid), 32'd0);
      clearQ();
      tick(8);
      checkStream("t4jb", 9, 4);

      // Wrap-around from 30, then an asynchronous reset mid-stream
      doReset();
      rstN = 1'b1; fetchEn = 1'b1; instrReady = 1'b1;
      tick(5);
      jmp = 1'b1; jmpTarget = 5'd30;
      tick(1);
      jmp = 1'b0;
      clearQ();
      tick(8);
      checkStream("t5wrap", 30, 4);
      checkEq("t5_pre_valid", 32'(instrValid), 32'd1);
      rstN = 1'b0;
      #1;
      checkEq("t5_arst_req", 32'(memReq), 32'd0);
      checkEq("t5_arst_addr", 32'(memAddr), 32'd0);
      checkEq("t5_arst_valid", 32'(instrValid), 32'd0);
      checkEq("t5_arst_out", instrOut, 32'd0);
      checkEq("t5_arst_pc", 32'(instrPc), 32'd0);
      clearQ();
      #4;
      rstN = 1'b1;
      tick(8);
      checkStream("t5rst", 0, 4);

      // fetchEn low for cycles 5..7: no requests in 6..8, stream stays contiguous
      doReset();
      rstN = 1'b1; fetchEn = 1'b1; instrReady = 1'b1;
      tick(5);
      fetchEn = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick(1);
         checkEq($sformatf("t6_noreq%0d", k), 32'(memReq), 32'd0);
      end
      fetchEn = 1'b1;
      tick(1);
      checkEq("t6_req_resume", 32'(memReq), 32'd1);
      checkEq("t6_addr_resume", 32'(memAddr), 32'd5);
      tick(10);
      checkStream("t6", 0, 10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
